// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter granting exclusive write ownership of one shared WIDTH-bit register.
// Optional hold limit: define DFF_ARB_HOLD_LIMIT_EN to force release after MAX_HOLD captures.
module dff_write_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     d_in,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy,
    output logic [WIDTH-1:0]           q
);
    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_check
        $error("dff_write_arbiter: N_REQ must be 2..8 and MAX_HOLD 1..255");
    end

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_t;

    state_t             r_state, w_state_nxt;
    logic [N_REQ-1:0]   r_grant, w_grant_nxt;
    logic [IDX_W-1:0]   r_owner, w_owner_nxt;
    logic [IDX_W-1:0]   r_last,  w_last_nxt;
    logic               r_busy,  w_busy_nxt;
    logic [WIDTH-1:0]   r_q;
    logic               w_cap;
    logic               w_any;
    logic [IDX_W-1:0]   w_pick;
    logic               w_hold_hit;

    // Scan starts just past the previous owner, so it becomes lowest priority.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_any && req[(int'(r_last) + k) % N_REQ]) begin
                w_any  = 1'b1;
                w_pick = IDX_W'((int'(r_last) + k) % N_REQ);
            end
        end
    end

`ifdef DFF_ARB_HOLD_LIMIT_EN
    logic [7:0] r_hold;

    assign w_hold_hit = (r_hold == 8'(MAX_HOLD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_hold <= '0;
        else
            r_hold <= w_cap ? r_hold + 8'd1 : 8'd0;
    end
`else
    assign w_hold_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_busy_nxt  = r_busy;
        w_last_nxt  = r_last;
        w_cap       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                w_owner_nxt = '0;
                w_busy_nxt  = 1'b0;
                if (w_any) begin
                    w_grant_nxt = N_REQ'(1) << w_pick;
                    w_owner_nxt = w_pick;
                    w_busy_nxt  = 1'b1;
                    w_last_nxt  = w_pick;
                    w_state_nxt = S_OWN;
                end
            end
            S_OWN: begin
                w_cap = req[r_owner];
                // Release on dropped request, or after the final allowed capture.
                if (!req[r_owner] || w_hold_hit) begin
                    w_grant_nxt = '0;
                    w_owner_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                w_grant_nxt = '0;
                w_owner_nxt = '0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_grant_nxt = '0;
                w_owner_nxt = '0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant <= '0;
            r_owner <= '0;
            r_busy  <= 1'b0;
            r_last  <= IDX_W'(N_REQ - 1);
            r_q     <= '0;
        end else begin
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_busy  <= w_busy_nxt;
            r_last  <= w_last_nxt;
            if (w_cap)
                r_q <= d_in[r_owner*WIDTH +: WIDTH];
        end
    end

    assign grant = r_grant;
    assign owner = r_owner;
    assign busy  = r_busy;
    assign q     = r_q;
endmodule

// File: tb/tb_dff_write_arbiter.sv
// Randomized and directed bench for dff_write_arbiter against a cycle-level ownership model.
// Hold-limit expectations follow DFF_ARB_HOLD_LIMIT_EN when the macro is defined.
`timescale 1ns/1ps
module tb_dff_write_arbiter;
    localparam int N  = 4;
    localparam int W  = 1;
    localparam int MH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   d_in = '0;
    logic [N-1:0]     grant;
    logic [$clog2(N)-1:0] owner;
    logic             busy;
    logic [W-1:0]     q;

    dff_write_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset), .req(req), .d_in(d_in),
        .grant(grant), .owner(owner), .busy(busy), .q(q)
    );

    always #42 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: owner (-1 = none), edges still to sit out after a release, captures so far.
    int         m_owner, m_cool, m_caps, m_last;
    logic [W-1:0] m_q;

    function automatic void model_reset();
        m_owner = -1; m_cool = 0; m_caps = 0; m_last = N - 1; m_q = '0;
    endfunction

    function automatic void model_step();
        if (reset) begin
            model_reset();
            return;
        end
        if (m_owner >= 0) begin
            if (req[m_owner]) begin
                m_q = d_in[m_owner*W +: W];
                m_caps++;
`ifdef DFF_ARB_HOLD_LIMIT_EN
                if (m_caps == MH) begin m_owner = -1; m_cool = 1; end
`endif
            end else begin
                m_owner = -1; m_cool = 1;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (req != 0) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (req[i]) begin
                    m_owner = i; m_last = i; m_caps = 0;
                    break;
                end
            end
        end
    endfunction

    task automatic check_all();
        logic [N-1:0] eg;
        eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        chk("grant", grant, eg);
        chk("owner", owner, (m_owner < 0) ? 0 : m_owner);
        chk("busy", busy, m_owner >= 0);
        chk("q", q, m_q);
        chk("onehot0", $onehot0(grant), 1);
        chk("busy_vs_grant", busy, |grant);
    endtask

    task automatic tick(input logic [N-1:0] r, input logic [N*W-1:0] d);
        req = r; d_in = d;
        @(posedge clk);
        model_step();
        #1 check_all();
    endtask

    // 20 ns reset pulse placed between edges.
    task automatic pulse_reset();
        #10 reset = 1'b1;
        #1 model_reset();
        check_all();
        chk("rst_q_now", q, 0);
        chk("rst_grant_now", grant, 0);
        #19 reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] r, prev_g;
        int order[$];
        int gap, g0_cnt;
        logic saw_g1;

        model_reset();
        // Reset held with everything requesting.
        reset = 1'b1;
        for (int t = 0; t < 3; t++) tick(4'b1111, 4'b1111);
        reset = 1'b0;
        tick(4'b1111, 4'b1111);
        chk("first_grant", grant, 4'b0001);
        chk("first_owner", owner, 0);

        // Single requester with toggling data.
        pulse_reset();
        tick(4'b0100, 4'b0000);
        chk("single_grant", grant, 4'b0100);
        tick(4'b0100, 4'b0100); chk("single_q1", q, 1);
        tick(4'b0100, 4'b0000); chk("single_q0", q, 0);
        tick(4'b0100, 4'b0100); chk("single_q1b", q, 1);
        tick(4'b0000, 4'b0000);
        chk("single_rel_grant", grant, 0);
        chk("single_hold_q", q, 1);

        // Round robin: each owner drops after two captures, then re-raises.
        pulse_reset();
        prev_g = '0; gap = 0;
        for (int t = 0; t < 60 && order.size() < 5; t++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_caps >= 2) r[m_owner] = 1'b0;
            tick(r, $urandom);
            if (grant != 0 && prev_g == 0) begin
                if (order.size() > 0) chk("rr_gap", gap, 2);
                order.push_back(int'(owner));
            end
            gap = (grant == 0) ? gap + 1 : 0;
            prev_g = grant;
        end
        chk("rr_count", order.size(), 5);
        foreach (order[j]) chk("rr_order", order[j], j % 4);

        // Hold limit: two constant requesters.
        pulse_reset();
        g0_cnt = 0; saw_g1 = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick(4'b0011, 4'b0011);
            if (t < 8 && grant == 4'b0001) g0_cnt++;
            if (grant[1]) saw_g1 = 1'b1;
        end
`ifdef DFF_ARB_HOLD_LIMIT_EN
        chk("hold_g0_cycles", g0_cnt, MH);
        chk("hold_g1_seen", saw_g1, 1);
`else
        chk("hold_g0_cycles", g0_cnt, 8);
        chk("hold_g1_seen", saw_g1, 0);
`endif

        // Async reset while owner 3 holds q=1.
        pulse_reset();
        tick(4'b1000, 4'b1000);
        tick(4'b1000, 4'b1000);
        chk("mid_q_before", q, 1);
        chk("mid_grant_before", grant, 4'b1000);
        pulse_reset();
        tick(4'b1000, 4'b1000);
        chk("mid_regrant", grant, 4'b1000);

        // Non-owner data must not reach q.
        pulse_reset();
        tick(4'b0010, 4'b0000);
        tick(4'b0010, 4'b0000);
        for (int t = 0; t < 3; t++) tick(4'b0110, 4'b0100);
        chk("iso_q_held", q, 0);
        chk("iso_owner", owner, 1);
        for (int t = 0; t < 4; t++) tick(4'b0100, 4'b0100);
        chk("iso_owner2", owner, 2);
        chk("iso_q_new", q, 1);

        // Random traffic with sticky requests and occasional resets.
        r = '0;
        for (int t = 0; t < 400; t++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            if ($urandom_range(0, 49) == 0) pulse_reset();
            else tick(r, N*W'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
